vga_scanout: RTL and testbench

- Read-side counterpart of the 160x120 framebuffer pixel writer.
- Generates 640x480@60 Hz VGA timing from clk50M (25 MHz pixel enable).
- Reads the framebuffer through a synchronous read port with 1-cycle latency; each framebuffer pixel is upscaled 4x4.
- Drives DAC/sync pins and a frame_start strobe that game logic uses to time redraws.

---
 rtl/vga_scanout.sv | 121 ++++++++++++
 tb/tb_vga_scanout.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of a 160x120 framebuffer, each framebuffer pixel shown 4x4.
// Framebuffer read through a synchronous 1-cycle-latency port; one-pixel output pipeline.
module vga_scanout #(
  parameter int COLOR_W = 3,
  parameter int FB_W    = 160,
  parameter int FB_H    = 120,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  localparam int ADDR_W = $clog2(FB_W * FB_H)
) (
  input  logic               clk50M,
  input  logic               rst_n,
  input  logic               scan_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [COLOR_W-1:0] rd_data,
  output logic               vga_clk,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               vga_sync_n,
  output logic [7:0]         vga_r,
  output logic [7:0]         vga_g,
  output logic [7:0]         vga_b,
  output logic               vblank,
  output logic               frame_start
);

  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] H_SS     = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SE     = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] V_SS     = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SE     = 10'(V_VIS + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);

  logic              phase;
  logic              tick;
  logic [9:0]        h_cnt;
  logic [9:0]        v_cnt;
  logic [9:0]        h_nxt;
  logic [9:0]        v_nxt;
  logic              vis_p0;
  logic              vis_p1;
  logic [ADDR_W-1:0] fx_p0;
  logic [ADDR_W-1:0] fy_p0;
  logic [ADDR_W-1:0] addr_p0;

  // Replicates one colour bit onto a DAC channel; a closed gate forces black even if the bit is X.
  function automatic logic [7:0] chan(input logic show, input logic b);
    return show ? {8{b}} : 8'h00;
  endfunction

  assign tick = phase;

  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
  end

  // Stage p0: address of the pixel about to be scanned, so RAM data lands by the end of its period
  always_comb begin
    vis_p0  = (h_nxt < H_VIS_C) && (v_nxt < V_VIS_C);
    fx_p0   = ADDR_W'(h_nxt[9:2]);
    fy_p0   = ADDR_W'(v_nxt[9:2]);
    addr_p0 = vis_p0 ? (fy_p0 << 7) + (fy_p0 << 5) + fx_p0 : '0;
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= 1'b0;
      h_cnt   <= '0;
      v_cnt   <= '0;
      rd_addr <= '0;
    end else begin
      phase <= ~phase;
      if (tick) begin
        h_cnt   <= h_nxt;
        v_cnt   <= v_nxt;
        rd_addr <= addr_p0;
      end
    end
  end

  // Stage p1: registered outputs for the pixel whose period ends at this tick
  assign vis_p1 = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= 8'h00;
      vga_g       <= 8'h00;
      vga_b       <= 8'h00;
    end else if (tick) begin
      vga_hs      <= ~((h_cnt >= H_SS) && (h_cnt <= H_SE));
      vga_vs      <= ~((v_cnt >= V_SS) && (v_cnt <= V_SE));
      vga_blank_n <= vis_p1;
      vga_r       <= chan(vis_p1 && scan_en, rd_data[COLOR_W-1]);
      vga_g       <= chan(vis_p1 && scan_en, rd_data[COLOR_W-2]);
      vga_b       <= chan(vis_p1 && scan_en, rd_data[COLOR_W-3]);
    end
  end

  assign vga_clk     = ~phase;
  assign vga_sync_n  = 1'b0;
  assign vblank      = (v_cnt >= V_VIS_C);
  assign frame_start = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout; vertical timing shortened to 8+2+2+1 lines so whole frames fit.
// Horizontal timing and address mapping keep their full 640x480 values.
module tb_vga_scanout;

  localparam int LINE = 1600;
  localparam int VTOT = 13;
  localparam int FR   = LINE * VTOT;

  logic        clk50M = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [14:0] rd_addr;
  logic [2:0]  rd_data = 3'b000;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vblank, frame_start;

  vga_scanout #(.V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(1)) dut (
    .clk50M(clk50M), .rst_n(rst_n), .scan_en(scan_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_r(vga_r),
    .vga_g(vga_g), .vga_b(vga_b), .vblank(vblank), .frame_start(frame_start)
  );

  always #10 clk50M = ~clk50M;

  // Framebuffer contents: address 0 is white, 161 is magenta, the rest a%5.
  function automatic logic [2:0] pat(input logic [14:0] a);
    if (a == 15'd0)   return 3'b111;
    if (a == 15'd161) return 3'b101;
    return 3'(a % 15'd5);
  endfunction

  always @(posedge clk50M) rd_data <= pat(rd_addr);

  int cyc;
  always @(posedge clk50M or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int hs_low = 0, vs_low = 0, vb_hi = 0, bn_hi = 0;
  int col_f0 = 0, col_f1 = 0, sig_diff = 0, blank_leak = 0;
  int fs_n = 0, fs_first = 0, fs_second = 0;
  logic [17:0] sig0 [FR];

  always @(negedge clk50M) begin
    if (!rst_n) begin
      fs_n = 0; fs_first = 0; fs_second = 0;
    end else begin
      if (frame_start) begin
        fs_n++;
        if (fs_n == 1) fs_first = cyc + 1;
        else if (fs_n == 2) fs_second = cyc + 1;
      end
      if (!vga_blank_n && {vga_r, vga_g, vga_b} != 24'h0) blank_leak++;
      if (cyc < FR) begin
        sig0[cyc] = {vga_hs, vga_vs, vga_blank_n, rd_addr};
        hs_low += int'(!vga_hs);
        vs_low += int'(!vga_vs);
        vb_hi  += int'(vblank);
        bn_hi  += int'(vga_blank_n);
        if (cyc >= 3202 && cyc <= 9601 && {vga_r, vga_g, vga_b} != 24'h0) col_f0++;
      end else if (cyc < 2 * FR) begin
        if ({vga_hs, vga_vs, vga_blank_n, rd_addr} != sig0[cyc - FR]) sig_diff++;
        if (cyc - FR >= 3202 && cyc - FR <= 9601 && {vga_r, vga_g, vga_b} != 24'h0) col_f1++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk50M); #1;
  endtask

  // Park in the tick cycle (phase 1) while the counters hold (h,v) of frame f.
  task automatic goto(input int f, input int h, input int v);
    int tgt;
    tgt = f * FR + 2 * (v * 800 + h) + 1;
    if (cyc > tgt) check("goto_order", cyc, tgt);
    while (cyc < tgt) step();
  endtask

  function automatic logic [31:0] pix();
    return {7'd0, vga_blank_n, vga_r, vga_g, vga_b};
  endfunction

  initial begin
    rst_n = 1'b0;
    scan_en = 1'b1;
    repeat (3) step();
    check("rst_addr", rd_addr, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_pix", pix(), 0);
    check("rst_vga_clk", vga_clk, 1);
    check("rst_vblank", vblank, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_sync_n", vga_sync_n, 0);

    rst_n = 1'b1;
    step();
    check("first_edge_clk", vga_clk, 0);
    check("first_edge_blank", vga_blank_n, 0);
    step();
    check("first_tick_clk", vga_clk, 1);
    check("pix_0_0", pix(), 32'h1FFFFFF);

    goto(0, 4, 4);
    check("addr_4_4", rd_addr, 161);
    for (int v = 4; v < 8; v++)
      for (int h = 4; h < 8; h++) begin
        goto(0, h, v); step();
        check($sformatf("pix_%0d_%0d", h, v), pix(), 32'h1FF00FF);
      end
    goto(0, 8, 7); step();
    check("pix_8_7", pix(), 32'h100FF00);
    goto(0, 639, 7);
    check("addr_639_7", rd_addr, 319);
    step();
    check("pix_639_7", pix(), 32'h1FF0000);
    goto(0, 640, 7);
    check("addr_640_7", rd_addr, 0);
    step();
    check("pix_640_7", pix(), 0);

    goto(0, 655, 7); step(); check("hs_655", vga_hs, 1);
    goto(0, 656, 7); step(); check("hs_656", vga_hs, 0);
    goto(0, 751, 7); step(); check("hs_751", vga_hs, 0);
    goto(0, 752, 7); step(); check("hs_752", vga_hs, 1);
    goto(0, 799, 7); check("vblank_line7", vblank, 0);
    goto(0, 0, 8);   check("vblank_line8", vblank, 1);
    step();          check("pix_0_8", pix(), 0);
    goto(0, 799, 9);  step(); check("vs_line9", vga_vs, 1);
    goto(0, 0, 10);   step(); check("vs_line10", vga_vs, 0);
    goto(0, 799, 11); step(); check("vs_line11", vga_vs, 0);
    goto(0, 0, 12);   step(); check("vs_line12", vga_vs, 1);
    goto(0, 799, 12);
    check("fs_at_end", frame_start, 1);
    check("vblank_last", vblank, 1);
    goto(1, 0, 0);
    check("fs_after_end", frame_start, 0);
    check("vblank_wrap", vblank, 0);

    goto(1, 0, 2); scan_en = 1'b0;
    goto(1, 0, 6); scan_en = 1'b1;
    goto(1, 4, 6); step(); check("scan_back_on", pix(), 32'h1FF00FF);
    goto(1, 5, 6); scan_en = 1'b0; step(); check("scan_midline_off", pix(), 32'h1000000);
    goto(1, 6, 6); scan_en = 1'b1; step(); check("scan_midline_on", pix(), 32'h1FF00FF);
    goto(2, 0, 0);

    check("hs_low_cycles", hs_low, VTOT * 192);
    check("vs_low_cycles", vs_low, 2 * LINE);
    check("vblank_cycles", vb_hi, 5 * LINE);
    check("blank_n_cycles", bn_hi, 640 * 8 * 2);
    check("colour_seen_f0", col_f0 > 0, 1);
    check("scan_off_colour", col_f1, 0);
    check("scan_off_sig_diff", sig_diff, 0);
    check("blank_leak", blank_leak, 0);
    check("fs_count", fs_n, 2);
    check("fs_first", fs_first, FR);
    check("fs_period", fs_second - fs_first, FR);

    goto(2, 300, 1);
    check("pre_reset_addr", rd_addr, 75);
    rst_n = 1'b0;
    #1;
    check("midrst_addr", rd_addr, 0);
    check("midrst_pix", pix(), 0);
    check("midrst_vga_clk", vga_clk, 1);
    check("midrst_hs_vs", {vga_hs, vga_vs}, 2'b11);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < FR + 20 && fs_n == 0; i++) step();
    check("fs_after_reset", fs_first, FR);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
